nes_video_feeder: RTL

- Sits between the NES PPU pixel output and the write port (vin0) of the SDRAM video frame buffer on Tang 25K.
- Captures each 256-pixel active NES scanline into a ping-pong line buffer of 6-bit palette indices.
- Replays each line 2x vertically and each pixel 2x horizontally through a registered RGB565 palette lookup, producing a 512x480 stream with frame-start vs_n and de, and honouring FIFO-full backpressure.

---
 rtl/nes_video_feeder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/nes_video_feeder.sv
// nes_video_feeder
//   Bridges the NES PPU pixel stream to the vin0 write port of the SDRAM
//   frame buffer. Each active scanline is captured as 6-bit palette indices
//   into one half of a ping-pong line buffer. The other half is replayed
//   twice (two output rows), each pixel twice (two output columns). The
//   replay goes through a registered RGB565 palette lookup. The result is a
//   2x-scaled stream with a frame-start pulse on vin_vs_n.
//
// Ports
//   clk            system clock, shared with the frame buffer vin0 port
//   resetn         asynchronous active-low reset
//   pix_valid      one-cycle strobe per PPU dot
//   pix_x, pix_y   PPU dot (0..340) and scanline (0..261)
//   pix_color      palette index of the current dot
//   vin_fifo_full  frame buffer write FIFO full; stalls word issue
//   vin_vs_n       frame start, low for VS_LEN cycles
//   vin_de         vin_data valid
//   vin_data       pixel as {B[4:0],G[5:0],R[4:0]}
//   overrun        sticky: a line was dropped in the current frame
//   drop_cnt       saturating count of dropped lines since reset

module nes_video_feeder #(
   parameter int H_ACTIVE = 256,
   parameter int V_ACTIVE = 240,
   parameter int VS_LEN   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pix_valid,
   input  logic [8:0]  pix_x,
   input  logic [8:0]  pix_y,
   input  logic [5:0]  pix_color,
   input  logic        vin_fifo_full,
   output logic        vin_vs_n,
   output logic        vin_de,
   output logic [15:0] vin_data,
   output logic        overrun,
   output logic [7:0]  drop_cnt
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int VW = (VS_LEN > 1) ? $clog2(VS_LEN) : 1;

   localparam logic [8:0]    H_LIM   = 9'(H_ACTIVE);
   localparam logic [8:0]    V_LIM   = 9'(V_ACTIVE);
   localparam logic [8:0]    X_END   = 9'(H_ACTIVE - 1);
   localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] VS_LAST = VW'(VS_LEN - 1);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      VSYNC      = 2'd1,
      RUN        = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [VW-1:0] vs_cnt;
   logic          run;

   logic          sof;
   logic          in_active;
   logic          cap_we;
   logic          line_end;

   logic          cap_bank;
   logic          drain_bank;
   logic          busy;
   logic [XW-1:0] x_cnt;
   logic          dup;
   logic          pass;
   logic          drain_last;

   logic          vld_p0;
   logic          vld_p1;
   logic [5:0]    idx_p1;

   logic [5:0]    line_mem [0:(2**(XW+1))-1];

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // 2C02 palette as 24-bit RGB, truncated to RGB565 packed as {B,G,R}.
   function automatic logic [15:0] pal565(input logic [5:0] idx);
      logic [23:0] rgb;
      case (idx)
         6'h00: rgb = 24'h626262;  6'h01: rgb = 24'h001FB2;  6'h02: rgb = 24'h2404C8;  6'h03: rgb = 24'h5200B2;
         6'h04: rgb = 24'h730076;  6'h05: rgb = 24'h800024;  6'h06: rgb = 24'h730B00;  6'h07: rgb = 24'h522800;
         6'h08: rgb = 24'h244400;  6'h09: rgb = 24'h005700;  6'h0A: rgb = 24'h005C00;  6'h0B: rgb = 24'h005324;
         6'h0C: rgb = 24'h003C76;  6'h0D: rgb = 24'h000000;  6'h0E: rgb = 24'h000000;  6'h0F: rgb = 24'h000000;
         6'h10: rgb = 24'hABABAB;  6'h11: rgb = 24'h0D57FF;  6'h12: rgb = 24'h4B30FF;  6'h13: rgb = 24'h8A13FF;
         6'h14: rgb = 24'hBC08D6;  6'h15: rgb = 24'hD21269;  6'h16: rgb = 24'hC72E00;  6'h17: rgb = 24'h9D5400;
         6'h18: rgb = 24'h607B00;  6'h19: rgb = 24'h209800;  6'h1A: rgb = 24'h00A300;  6'h1B: rgb = 24'h009942;
         6'h1C: rgb = 24'h007DB4;  6'h1D: rgb = 24'h000000;  6'h1E: rgb = 24'h000000;  6'h1F: rgb = 24'h000000;
         6'h20: rgb = 24'hFFFFFF;  6'h21: rgb = 24'h53AEFF;  6'h22: rgb = 24'h9085FF;  6'h23: rgb = 24'hD365FF;
         6'h24: rgb = 24'hFF57FF;  6'h25: rgb = 24'hFF5DCF;  6'h26: rgb = 24'hFF7757;  6'h27: rgb = 24'hFA9E00;
         6'h28: rgb = 24'hBDC700;  6'h29: rgb = 24'h7AE700;  6'h2A: rgb = 24'h43F611;  6'h2B: rgb = 24'h26EF7E;
         6'h2C: rgb = 24'h2CD5F6;  6'h2D: rgb = 24'h4E4E4E;  6'h2E: rgb = 24'h000000;  6'h2F: rgb = 24'h000000;
         6'h30: rgb = 24'hFFFFFF;  6'h31: rgb = 24'hB6E1FF;  6'h32: rgb = 24'hCED1FF;  6'h33: rgb = 24'hE9C3FF;
         6'h34: rgb = 24'hFFBCFF;  6'h35: rgb = 24'hFFBDF4;  6'h36: rgb = 24'hFFC6C3;  6'h37: rgb = 24'hFFD59A;
         6'h38: rgb = 24'hE9E681;  6'h39: rgb = 24'hCEF481;  6'h3A: rgb = 24'hB6FB9A;  6'h3B: rgb = 24'hA9FAC3;
         6'h3C: rgb = 24'hA9F0F4;  6'h3D: rgb = 24'hB8B8B8;  6'h3E: rgb = 24'h000000;  6'h3F: rgb = 24'h000000;
         default: rgb = 24'h000000;
      endcase
      return {5'(rgb[7:0] >> 3), 6'(rgb[15:8] >> 2), 5'(rgb[23:16] >> 3)};
   endfunction

   assign sof        = pix_valid && (pix_x == 9'd0) && (pix_y == 9'd0);
   assign in_active  = pix_valid && (pix_x < H_LIM) && (pix_y < V_LIM);
   // The (0,0) dot is captured even though it arrives while still in WAIT_FRAME.
   assign cap_we     = in_active && ((state != WAIT_FRAME) || sof);
   assign line_end   = cap_we && (pix_x == X_END);
   assign drain_last = pass && dup && (x_cnt == X_LAST);
   // A frame start in the same cycle wins over issue so the aborted line
   // cannot leak a word.
   assign vld_p0     = busy && run && !vin_fifo_full && !sof;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= WAIT_FRAME;
         vs_cnt <= '0;
      end else begin
         state <= state_next;
         if (sof)
            vs_cnt <= '0;
         else if (state == VSYNC)
            vs_cnt <= vs_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         WAIT_FRAME: state_next = WAIT_FRAME;
         VSYNC:      if (vs_cnt == VS_LAST) state_next = RUN;
         RUN:        state_next = RUN;
         default:    state_next = WAIT_FRAME;
      endcase
      if (sof)
         state_next = VSYNC;
   end

   always_comb begin
      vin_vs_n = 1'b1;
      run      = 1'b0;
      case (state)
         VSYNC:   vin_vs_n = 1'b0;
         RUN:     run = 1'b1;
         default: ;
      endcase
   end

   // Bank hand-off and drain issue pointer. Word order within a line is
   // {pass, x, dup}, so each pixel goes out twice per row and each row twice.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_bank   <= 1'b0;
         drain_bank <= 1'b0;
         busy       <= 1'b0;
         x_cnt      <= '0;
         dup        <= 1'b0;
         pass       <= 1'b0;
         overrun    <= 1'b0;
         drop_cnt   <= 8'd0;
      end else if (sof) begin
         busy    <= 1'b0;
         x_cnt   <= '0;
         dup     <= 1'b0;
         pass    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (vld_p0) begin
            dup <= ~dup;
            if (dup) begin
               if (x_cnt == X_LAST) begin
                  x_cnt <= '0;
                  pass  <= ~pass;
               end else begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end
            if (drain_last)
               busy <= 1'b0;
         end
         // A busy drainer means the finished line has nowhere to go; keep
         // the bank so the next line overwrites it.
         if (line_end) begin
            if (!busy) begin
               busy       <= 1'b1;
               drain_bank <= cap_bank;
               cap_bank   <= ~cap_bank;
            end else begin
               overrun  <= 1'b1;
               drop_cnt <= sat_inc(drop_cnt);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_we)
         line_mem[{cap_bank, pix_x[XW-1:0]}] <= pix_color;
   end

   // p0 -> p1: line buffer read
   always_ff @(posedge clk) begin
      idx_p1 <= line_mem[{drain_bank, x_cnt}];
   end

   // p1 -> p2: palette lookup onto the output port
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_p1   <= 1'b0;
         vin_de   <= 1'b0;
         vin_data <= 16'd0;
      end else begin
         vld_p1 <= vld_p0;
         vin_de <= vld_p1 && !sof;
         if (vld_p1 && !sof)
            vin_data <= pal565(idx_p1);
      end
   end

endmodule
